// File: rtl/audio_seq.sv
// Multi-track audio sample-address sequencer: looping music on track 0, priority
// one-shot effects on tracks 1..NUM_TRK-1, stepped at a fixed rate gated by data_over.
module audio_seq #(
  parameter int ADDR_W  = 17,
  parameter int DIV     = 122,
  parameter int NUM_TRK = 4,
  parameter int TW      = $clog2(NUM_TRK)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      INIT_FINISH,
  output logic                      INIT,
  input  logic                      data_over,
  input  logic [NUM_TRK*ADDR_W-1:0] trk_base,
  input  logic [NUM_TRK*ADDR_W-1:0] trk_len,
  input  logic [NUM_TRK-2:0]        play_req,
  input  logic                      music_en,
  output logic [ADDR_W-1:0]         Add,
  output logic [TW-1:0]             cur_trk,
  output logic                      fx_busy,
  output logic                      fx_done,
  output logic                      dbg_run_o
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_TRK-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0]   fx_off_q, fx_off_d;
  logic [ADDR_W-1:0]   mus_off_q, mus_off_d;
  logic [ADDR_W-1:0]   add_q, add_d;
  logic [TW-1:0]       trk_q, trk_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                init_q;

  logic [ADDR_W-1:0]   base_w [NUM_TRK];
  logic [ADDR_W-1:0]   len_w  [NUM_TRK];
  logic [NUM_TRK-1:0]  req_ok;
  logic                hit;
  logic [TW-1:0]       h;
  logic                tick;
  logic                start;
  logic [ADDR_W-1:0]   mus_nxt;
  logic [ADDR_W-1:0]   fx_len;

  always_comb begin
    req_ok = '0;
    for (int i = 0; i < NUM_TRK; i++) begin
      base_w[i] = trk_base[i*ADDR_W +: ADDR_W];
      len_w[i]  = trk_len[i*ADDR_W +: ADDR_W];
    end
    // Zero-length effects can never play, so their requests are dropped here.
    for (int j = 0; j < NUM_TRK - 1; j++) begin
      req_ok[j+1] = play_req[j] && (len_w[j+1] != '0);
    end
  end

  always_comb begin
    hit = 1'b0;
    h   = '0;
    for (int i = 1; i < NUM_TRK; i++) begin
      if (pend_q[i]) begin
        hit = 1'b1;
        h   = TW'(i);
      end
    end
  end

  assign tick    = (state_q == ST_RUN) && (cnt_q == CW'(DIV - 1));
  assign fx_len  = len_w[trk_q];
  assign mus_nxt = (len_w[0] == '0 || mus_off_q == len_w[0] - 1'b1) ? '0 : mus_off_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | req_ok;
    fx_off_d  = fx_off_q;
    mus_off_d = mus_off_q;
    add_d     = add_q;
    trk_d     = trk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        if (INIT_FINISH) begin
          state_d   = ST_RUN;
          add_d     = base_w[0];
          trk_d     = '0;
          mus_off_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && data_over) begin
          if (hit && (!busy_q || h > trk_q)) begin
            // Music resumes one sample past the point where it was cut off.
            if (!busy_q) mus_off_d = mus_nxt;
            start = 1'b1;
          end else if (busy_q && fx_off_q == fx_len - 1'b1) begin
            done_d = 1'b1;
            if (hit) begin
              start = 1'b1;
            end else begin
              busy_d = 1'b0;
              trk_d  = '0;
              add_d  = base_w[0] + mus_off_q;
            end
          end else if (busy_q) begin
            fx_off_d = fx_off_q + 1'b1;
            add_d    = base_w[trk_q] + fx_off_q + 1'b1;
          end else if (music_en && len_w[0] != '0) begin
            mus_off_d = mus_nxt;
            add_d     = base_w[0] + mus_nxt;
          end
          if (start) begin
            trk_d     = h;
            fx_off_d  = '0;
            add_d     = base_w[h];
            pend_d[h] = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      pend_q    <= '0;
      fx_off_q  <= '0;
      mus_off_q <= '0;
      add_q     <= '0;
      trk_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      fx_off_q  <= fx_off_d;
      mus_off_q <= mus_off_d;
      add_q     <= add_d;
      trk_q     <= trk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      init_q    <= 1'b1;
    end
  end

  assign INIT      = init_q;
  assign Add       = add_q;
  assign cur_trk   = trk_q;
  assign fx_busy   = busy_q;
  assign fx_done   = done_q;
  assign dbg_run_o = (state_q == ST_RUN);
endmodule

// File: tb/tb_audio_seq.sv
// Bench for audio_seq: directed step table for the init/stall/effect/priority scenarios,
// an async reset check, then randomized traffic against a sample-level reference model.
module tb_audio_seq;
  localparam int ADDR_W  = 17;
  localparam int DIV     = 4;
  localparam int NUM_TRK = 4;
  localparam int TW      = 2;

  logic                      Clk = 1'b0;
  logic                      Reset_n = 1'b0;
  logic                      INIT_FINISH = 1'b0;
  logic                      INIT;
  logic                      data_over = 1'b1;
  logic [NUM_TRK*ADDR_W-1:0] trk_base = '0;
  logic [NUM_TRK*ADDR_W-1:0] trk_len = '0;
  logic [NUM_TRK-2:0]        play_req = '0;
  logic                      music_en = 1'b1;
  logic [ADDR_W-1:0]         Add;
  logic [TW-1:0]             cur_trk;
  logic                      fx_busy;
  logic                      fx_done;
  logic                      dbg_run_o;

  audio_seq #(.ADDR_W(ADDR_W), .DIV(DIV), .NUM_TRK(NUM_TRK)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
    .data_over(data_over), .trk_base(trk_base), .trk_len(trk_len),
    .play_req(play_req), .music_en(music_en), .Add(Add), .cur_trk(cur_trk),
    .fx_busy(fx_busy), .fx_done(fx_done), .dbg_run_o(dbg_run_o)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One table row covers one sample period: pulse req in its first cycle, check after the step.
  typedef struct {
    logic [2:0]        req;
    logic              dover;
    logic              men;
    logic [ADDR_W-1:0] add;
    logic [TW-1:0]     trk;
    logic              busy;
    logic              done;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [2:0] req, input logic dover, input logic men,
                   input int add, input int trk, input logic busy, input logic done);
    vec_t e;
    e.req = req; e.dover = dover; e.men = men;
    e.add = ADDR_W'(add); e.trk = TW'(trk); e.busy = busy; e.done = done;
    tbl.push_back(e);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      data_over = tbl[i].dover;
      music_en  = tbl[i].men;
      play_req  = tbl[i].req;
      @(posedge Clk); #1;
      play_req = '0;
      repeat (DIV - 1) @(posedge Clk);
      #1;
      check($sformatf("vec%0d_add", i), 32'(Add), 32'(tbl[i].add));
      check($sformatf("vec%0d_trk", i), 32'(cur_trk), 32'(tbl[i].trk));
      check($sformatf("vec%0d_busy", i), 32'(fx_busy), 32'(tbl[i].busy));
      check($sformatf("vec%0d_done", i), 32'(fx_done), 32'(tbl[i].done));
    end
    tbl.delete();
  endtask

  task automatic set_trk(input int t, input int base, input int len);
    trk_base[t*ADDR_W +: ADDR_W] = ADDR_W'(base);
    trk_len[t*ADDR_W +: ADDR_W]  = ADDR_W'(len);
  endtask

  // Reference model: works on whole samples and track numbers, not the RTL's encoding.
  int     mbase[NUM_TRK];
  int     mlen[NUM_TRK];
  bit     m_run, m_busy, m_done, m_init;
  bit     m_pend[NUM_TRK];
  int     m_cnt, m_cur, m_off, m_mus, m_add;

  function automatic int wrap_addr(input int a);
    return a % (1 << ADDR_W);
  endfunction

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_done = 0; m_init = 0;
    m_cnt = 0; m_cur = 0; m_off = 0; m_mus = 0; m_add = 0;
    for (int i = 0; i < NUM_TRK; i++) m_pend[i] = 0;
  endtask

  task automatic model_edge(input bit ifin, input bit dov, input logic [2:0] req, input bit men);
    int  top;
    bit  tick;
    bit  np[NUM_TRK];
    bit  go;
    go = 0;
    m_init = 1;
    m_done = 0;
    top = -1;
    for (int i = 1; i < NUM_TRK; i++) if (m_pend[i]) top = i;
    for (int i = 0; i < NUM_TRK; i++) np[i] = m_pend[i];
    for (int j = 0; j < NUM_TRK - 1; j++) if (req[j] && mlen[j+1] != 0) np[j+1] = 1;
    if (!m_run) begin
      if (ifin) begin
        m_run = 1; m_cnt = 0; m_add = mbase[0]; m_cur = 0; m_mus = 0;
      end
    end else begin
      tick  = (m_cnt == DIV - 1);
      m_cnt = (m_cnt + 1) % DIV;
      if (tick && dov) begin
        if (top >= 0 && (!m_busy || top > m_cur)) begin
          if (!m_busy) m_mus = (mlen[0] != 0) ? (m_mus + 1) % mlen[0] : 0;
          go = 1;
        end else if (m_busy && m_off == mlen[m_cur] - 1) begin
          m_done = 1;
          if (top >= 0) go = 1;
          else begin
            m_busy = 0; m_cur = 0; m_add = wrap_addr(mbase[0] + m_mus);
          end
        end else if (m_busy) begin
          m_off++;
          m_add = wrap_addr(mbase[m_cur] + m_off);
        end else if (men && mlen[0] != 0) begin
          m_mus = (m_mus + 1) % mlen[0];
          m_add = wrap_addr(mbase[0] + m_mus);
        end
        if (go) begin
          m_cur = top; m_off = 0; m_add = mbase[top]; np[top] = 0; m_busy = 1;
        end
      end
    end
    for (int i = 0; i < NUM_TRK; i++) m_pend[i] = np[i];
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d_add", cyc), 32'(Add), 32'(m_add));
    check($sformatf("rnd%0d_trk", cyc), 32'(cur_trk), 32'(m_cur));
    check($sformatf("rnd%0d_busy", cyc), 32'(fx_busy), 32'(m_busy));
    check($sformatf("rnd%0d_done", cyc), 32'(fx_done), 32'(m_done));
    check($sformatf("rnd%0d_init", cyc), 32'(INIT), 32'(m_init));
  endtask

  initial begin
    set_trk(0, 100, 3);
    set_trk(1, 300, 2);
    set_trk(2, 500, 2);
    set_trk(3, 700, 3);

    // Reset and init handshake
    #12;
    check("rst_add", 32'(Add), 0);
    check("rst_init", 32'(INIT), 0);
    check("rst_run", 32'(dbg_run_o), 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("init_after_edge", 32'(INIT), 1);
    check("wait_add", 32'(Add), 0);
    repeat (20) @(posedge Clk);
    #1;
    check("wait20_add", 32'(Add), 0);
    check("wait20_run", 32'(dbg_run_o), 0);
    INIT_FINISH = 1'b1;
    @(posedge Clk); #1;
    check("entry_add", 32'(Add), 100);
    check("entry_run", 32'(dbg_run_o), 1);

    // Music stepping, stall, effect/resume, priority, pre-emption
    v(3'b000, 1, 1, 101, 0, 0, 0);
    v(3'b000, 1, 1, 102, 0, 0, 0);
    v(3'b000, 1, 1, 100, 0, 0, 0);
    v(3'b000, 1, 1, 101, 0, 0, 0);
    v(3'b000, 0, 1, 101, 0, 0, 0);
    v(3'b000, 0, 1, 101, 0, 0, 0);
    v(3'b000, 0, 1, 101, 0, 0, 0);
    v(3'b000, 1, 1, 102, 0, 0, 0);
    v(3'b000, 1, 1, 100, 0, 0, 0);
    v(3'b000, 1, 1, 101, 0, 0, 0);
    v(3'b010, 1, 1, 500, 2, 1, 0);
    v(3'b000, 1, 1, 501, 2, 1, 0);
    v(3'b000, 1, 1, 102, 0, 0, 1);
    v(3'b000, 1, 1, 100, 0, 0, 0);
    v(3'b101, 1, 1, 700, 3, 1, 0);
    v(3'b001, 1, 1, 701, 3, 1, 0);
    v(3'b000, 1, 1, 702, 3, 1, 0);
    v(3'b000, 1, 1, 300, 1, 1, 1);
    v(3'b000, 1, 1, 301, 1, 1, 0);
    v(3'b000, 1, 1, 101, 0, 0, 1);
    v(3'b001, 1, 1, 300, 1, 1, 0);
    v(3'b100, 1, 1, 700, 3, 1, 0);
    v(3'b000, 1, 1, 701, 3, 1, 0);
    v(3'b000, 1, 1, 702, 3, 1, 0);
    v(3'b000, 1, 1, 102, 0, 0, 1);
    run_table();

    // Zero-length request ignored, music_en freeze, then an effect for the reset test
    set_trk(1, 300, 0);
    v(3'b001, 1, 1, 100, 0, 0, 0);
    v(3'b000, 1, 0, 100, 0, 0, 0);
    v(3'b000, 1, 0, 100, 0, 0, 0);
    v(3'b000, 1, 1, 101, 0, 0, 0);
    v(3'b010, 1, 1, 500, 2, 1, 0);
    run_table();

    // Asynchronous reset away from any clock edge
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_add", 32'(Add), 0);
    check("arst_trk", 32'(cur_trk), 0);
    check("arst_busy", 32'(fx_busy), 0);
    check("arst_init", 32'(INIT), 0);
    check("arst_run", 32'(dbg_run_o), 0);

    // Randomized traffic against the reference model
    for (int round = 0; round < 4; round++) begin
      int rise;
      Reset_n     = 1'b0;
      INIT_FINISH = 1'b0;
      play_req    = '0;
      for (int t = 0; t < NUM_TRK; t++) begin
        mbase[t] = $urandom_range(0, (1 << ADDR_W) - 1);
        mlen[t]  = (t == 0) ? $urandom_range(1, 5) : $urandom_range(0, 4);
        set_trk(t, mbase[t], mlen[t]);
      end
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
      rise = $urandom_range(0, 25);
      for (int cyc = 0; cyc < 700; cyc++) begin
        INIT_FINISH = (cyc >= rise);
        data_over   = ($urandom_range(0, 3) != 0);
        music_en    = ($urandom_range(0, 4) != 0);
        play_req    = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        @(posedge Clk);
        model_edge(INIT_FINISH, data_over, play_req, music_en);
        #1;
        check_model(cyc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_seq.md
Name: audio_seq

Overview:
- Multi-track audio sample-address sequencer sitting between game logic and the audio ROM/codec path.
- Waits for codec initialisation, then steps a ROM address at a fixed sample rate, gated by the codec's data_over.
- Track 0 is looping background music. Tracks 1..NUM_TRK-1 are one-shot sound effects that pre-empt music by priority. Music resumes where it left off.

Parameters:
- ADDR_W, 17, ROM address width.
- DIV, 122, clocks per sample tick; must be >= 2.
- NUM_TRK, 4, number of tracks; track 0 = music; must be >= 2.
- TW, $clog2(NUM_TRK), track index width (derived).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- INIT_FINISH  in  1  codec init complete (level).
- INIT  out  1  codec init request.
- data_over  in  1  codec consumed current sample (level, sampled on tick).
- trk_base  in  NUM_TRK*ADDR_W  start address per track; track i at [i*ADDR_W +: ADDR_W]; static while running.
- trk_len  in  NUM_TRK*ADDR_W  sample count per track; same packing.
- play_req  in  NUM_TRK-1  one-cycle effect requests; bit j = track j+1.
- music_en  in  1  1 = music plays when no effect is active.
- Add  out  ADDR_W  registered sample address.
- cur_trk  out  TW  track currently addressed.
- fx_busy  out  1  an effect is playing.
- fx_done  out  1  one-cycle pulse when an effect finishes.

Behaviour:
- Reset (async, immediate, any state):
  - state = WAIT; div counter = 0; offsets, saved music offset and pending = 0.
  - Add = 0, cur_trk = 0, fx_busy = 0, fx_done = 0, INIT = 0.
- INIT: registered. 1 from the first clock edge after reset release and stays 1.
- States:
  - WAIT: Add held at 0. Go to RUN on the edge where INIT_FINISH = 1. On entry: Add = trk_base[0], cur_trk = 0, music offset = 0.
  - RUN: no exit except reset.
- Divider (RUN only):
  - Counts 0..DIV-1, wraps to 0.
  - tick = (count == DIV-1).
  - Held at 0 in WAIT.
- Pending requests:
  - play_req[j] sets pending[j+1] every cycle, including WAIT.
  - A request for a track whose trk_len = 0 is ignored.
  - A request for an already-pending track has no further effect.
- Step event = tick && data_over in RUN. A tick with data_over = 0 changes nothing: no advance, no switch, pending retained.
- At a step event, in priority order:
  1. Pre-empt/start. Let h = highest-index pending track. If h exists and (no effect active, or h > current effect):
     - If music was current, save music offset = (offset+1) wrapped at trk_len[0].
     - cur_trk = h; effect offset = 0; Add = trk_base[h]; clear pending[h]; fx_busy = 1.
     - A pre-empted lower effect is abandoned; it is not re-queued.
  2. Else, if an effect is active and its offset == trk_len-1:
     - Effect ends; fx_done = 1 for this cycle.
     - If any pending, start the highest pending as in step 1.
     - Else fx_busy = 0, cur_trk = 0, Add = trk_base[0] + saved music offset.
  3. Else, if an effect is active: offset+1; Add = base + offset.
  4. Else (music): if music_en = 1 and trk_len[0] != 0, offset = (offset == trk_len[0]-1) ? 0 : offset+1, and Add follows. Otherwise hold.
- Arithmetic: Add = base + offset, modulo 2^ADDR_W, no overflow flag.
- music_en = 0 freezes the music offset; effects are unaffected.
- fx_done is 0 in every cycle other than an effect-end step.

Test Plan:
- Init handshake (DIV = 4, NUM_TRK = 4, base0 = 100, len0 = 3, data_over = 1):
  - Release reset -> INIT = 1 after one edge, Add = 0.
  - Hold INIT_FINISH = 0 for 20 cycles -> Add stays 0.
  - Assert INIT_FINISH -> Add = 100.
  - Ticks every 4 clocks -> Add sequence 101, 102, 100, 101.
- Stall: data_over = 0 across 3 ticks -> Add frozen; raise data_over -> advances one step per tick.
- Effect and resume (base2 = 500, len2 = 2):
  - Pulse play_req[1] while music is at offset 1 -> next step gives Add = 500, cur_trk = 2, fx_busy = 1; then 501.
  - Next step -> fx_done pulse, Add = 102 (saved offset 2), fx_busy = 0.
- Priority:
  - Pulse play_req[0] and play_req[2] in the same cycle -> track 3 plays first, then track 1, then music.
  - Pulse play_req[0] during track 3 -> no pre-emption.
  - Pulse play_req[2] during track 1 -> immediate switch to track 3 at next step; track 1 is not replayed.
- Edge cases:
  - trk_len[1] = 0 request -> ignored.
  - music_en = 0 -> Add holds at current music address.
  - Async Reset_n pulse mid-effect, not clock-aligned -> all outputs 0 immediately and state returns to WAIT.
